// File: rtl/vga_pkg.sv
// Shared constants and FSM state type for the score text buffer.
// Holds ASCII codes for space and '0' plus the conversion FSM states.
package vga_pkg;

  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam logic [6:0] ASCII_ZERO  = 7'h30;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/bcd_convert.sv
// Double-dabble binary to BCD converter, one bit per cycle.
// Ports: start_i/value_i load, busy_o while stepping, valid_o on last step, bcd_o.
module bcd_convert
  import vga_pkg::*;
#(
  parameter int VALUE_W = 16,
  parameter int DIGITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [VALUE_W-1:0]    value_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int CW = $clog2(VALUE_W + 1);

  logic [CW-1:0]         steps_q;
  logic [VALUE_W-1:0]    sh_q;
  logic [4*DIGITS-1:0]   bcd_q;
  logic [4*DIGITS-1:0]   adj;

  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      steps_q <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
    end else if (start_i) begin
      steps_q <= CW'(VALUE_W);
      sh_q    <= value_i;
      bcd_q   <= '0;
    end else if (busy_o) begin
      steps_q <= steps_q - 1'b1;
      sh_q    <= {sh_q[VALUE_W-2:0], 1'b0};
      bcd_q   <= {adj[4*DIGITS-2:0], sh_q[VALUE_W-1]};
    end
  end

  assign busy_o  = (steps_q != '0);
  // Result is complete after the edge that ends this cycle.
  assign valid_o = (steps_q == CW'(1));
  assign bcd_o   = bcd_q;

endmodule

// File: rtl/score_text_buffer.sv
// Score text buffer: "PREFIX" + decimal score as a character read port.
// Ports: clk, rst (async low), value/update in, busy/done out, char_xy -> char_code.
// Build option SCORE_LZ_BLANK_EN blanks leading zero digits.
// Text length TEXT_SIZE = PREFIX_LEN + DIGITS; char_code is registered.
module score_text_buffer
  import vga_pkg::*;
#(
  parameter int                      PREFIX_LEN = 7,
  parameter logic [8*PREFIX_LEN-1:0] PREFIX     = "SCORE: ",
  parameter int                      VALUE_W    = 16,
  parameter int                      DIGITS     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value,
  input  logic               update,
  output logic               busy,
  output logic               done,
  input  logic [7:0]         char_xy,
  output logic [6:0]         char_code
);

  localparam int TEXT_SIZE = PREFIX_LEN + DIGITS;
  localparam int WI = $clog2(DIGITS + 1);

  state_e state_q, state_d;
  logic   start;
  logic   cvt_busy;
  logic   cvt_valid;
  logic [4*DIGITS-1:0] bcd;

  logic [WI-1:0] wr_q;
  logic [3:0]    shadow_q [DIGITS];
  logic [3:0]    vis_q    [DIGITS];
  logic [6:0]    dchar    [DIGITS];
  logic [6:0]    code_d;

  bcd_convert #(
    .VALUE_W (VALUE_W),
    .DIGITS  (DIGITS)
  ) u_cvt (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .value_i (value),
    .busy_o  (cvt_busy),
    .valid_o (cvt_valid),
    .bcd_o   (bcd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (update) begin
          start   = 1'b1;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        busy = 1'b1;
        if (cvt_valid)
          state_d = ST_WRITE;
        else if (!cvt_busy)
          state_d = ST_IDLE;
      end
      ST_WRITE: begin
        busy = 1'b1;
        if (wr_q == WI'(DIGITS - 1))
          state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow fills MS digit first; visible copy happens whole at the DONE edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      for (int k = 0; k < DIGITS; k++) begin
        shadow_q[k] <= '0;
        vis_q[k]    <= '0;
      end
    end else begin
      if (state_q == ST_WRITE) wr_q <= wr_q + 1'b1;
      else                     wr_q <= '0;
      for (int k = 0; k < DIGITS; k++) begin
        if (state_q == ST_WRITE && wr_q == WI'(k))
          shadow_q[k] <= bcd[4*(DIGITS-1-k) +: 4];
        if (state_q == ST_DONE)
          vis_q[k] <= shadow_q[k];
      end
    end
  end

`ifdef SCORE_LZ_BLANK_EN
  logic lz;
  always_comb begin
    lz = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      lz       = lz && (vis_q[k] == 4'd0) && (k != DIGITS - 1);
      dchar[k] = lz ? ASCII_SPACE : (ASCII_ZERO + {3'b0, vis_q[k]});
    end
  end
`else
  always_comb begin
    for (int k = 0; k < DIGITS; k++)
      dchar[k] = ASCII_ZERO + {3'b0, vis_q[k]};
  end
`endif

  always_comb begin
    code_d = ASCII_SPACE;
    if (char_xy < 8'(TEXT_SIZE)) begin
      for (int k = 0; k < PREFIX_LEN; k++)
        if (char_xy == 8'(k))
          code_d = PREFIX[8*(PREFIX_LEN-1-k) +: 7];
      for (int k = 0; k < DIGITS; k++)
        if (char_xy == 8'(PREFIX_LEN + k))
          code_d = dchar[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) char_code <= 7'h00;
    else      char_code <= code_d;
  end

endmodule

// File: tb/tb_score_text_buffer.sv
// Randomized self-checking bench for score_text_buffer.
// Text reference is built from the score with plain decimal arithmetic.
module tb_score_text_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value = '0;
  logic        update = 1'b0;
  logic        busy;
  logic        done;
  logic [7:0]  char_xy = '0;
  logic [6:0]  char_code;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  score_text_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .update    (update),
    .busy      (busy),
    .done      (done),
    .char_xy   (char_xy),
    .char_code (char_code)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic string txt(input int v);
    string s;
    int    d;
    bit    lead;
    s    = "SCORE: 00000";
    lead = 1'b1;
    for (int k = 0; k < 5; k++) begin
      d = (v / (10 ** (4 - k))) % 10;
      lead = lead && (d == 0) && (k != 4);
`ifdef SCORE_LZ_BLANK_EN
      s.putc(7 + k, lead ? 8'h20 : 8'(8'h30 + d));
`else
      s.putc(7 + k, 8'(8'h30 + d));
`endif
    end
    return s;
  endfunction

  function automatic int exp_chr(input string t, input logic [7:0] i);
    if (i < 8'd12) return int'(t[i]) & 32'h7f;
    return 32'h20;
  endfunction

  task automatic sweep(input string t, input string tag);
    int idx [16];
    for (int i = 0; i < 14; i++) idx[i] = i;
    idx[14] = 255;
    idx[15] = 128;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      char_xy = 8'(idx[i]);
      @(negedge clk);
      chk(tag, int'(char_code), exp_chr(t, char_xy));
    end
  endtask

  task automatic run_conv(input int v, input bit inject,
                          input string old_t, input string new_t);
    int nb, nd, dat;
    logic [7:0] prev;
    nb = 0;
    nd = 0;
    dat = -1;
    @(negedge clk);
    value  = 16'(v);
    update = 1'b1;
    @(posedge clk);
    #1;
    update = 1'b0;
    value  = 16'($urandom);
    prev   = char_xy;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        nd++;
        dat = c;
      end
      if (c >= 2 && c <= 22)
        chk("old_txt", int'(char_code), exp_chr(old_t, prev));
      if (c >= 25)
        chk("new_txt", int'(char_code), exp_chr(new_t, prev));
      update  = inject && (c == 5 || c == 22);
      value   = 16'($urandom);
      prev    = 8'(7 + $urandom_range(0, 6));
      char_xy = prev;
    end
    update = 1'b0;
    chk("busy_cycles", nb, 21);
    chk("done_count", nd, 1);
    chk("done_cycle", dat, 22);
  endtask

  initial begin
    int v, pv;
    #2;
    chk("rst_code", int'(char_code), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    sweep(txt(0), "reset_txt");

    run_conv(1234, 1'b0, txt(0), txt(1234));
    sweep(txt(1234), "txt_1234");
    run_conv(65535, 1'b0, txt(1234), txt(65535));
    run_conv(0, 1'b0, txt(65535), txt(0));
    sweep(txt(0), "txt_0");
    run_conv(500, 1'b1, txt(0), txt(500));
    sweep(txt(500), "txt_500");

    pv = 500;
    for (int r = 0; r < 5; r++) begin
      v = int'($urandom_range(0, 65535));
      run_conv(v, r[0], txt(pv), txt(v));
      pv = v;
    end
    sweep(txt(pv), "txt_rand");

    @(negedge clk);
    value  = 16'd4321;
    update = 1'b1;
    @(posedge clk);
    #1;
    update = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_code", int'(char_code), 0);
    @(negedge clk);
    rst = 1'b1;
    begin
      int nd;
      int nb;
      nd = 0;
      nb = 0;
      repeat (30) begin
        @(negedge clk);
        if (done) nd++;
        if (busy) nb++;
      end
      chk("post_rst_done", nd, 0);
      chk("post_rst_busy", nb, 0);
    end
    sweep(txt(0), "post_rst_txt");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
